// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one outstanding fetch at a time
// and hands each instruction with its PC to decode over valid/ready.
module ifu_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [XLEN-1:0] ifu_rsp_data,
  output logic            ifu_inst_valid,
  input  logic            ifu_inst_ready,
  output logic [XLEN-1:0] ifu_inst,
  output logic [XLEN-1:0] ifu_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            flush;       // next response belongs to an abandoned request
  logic            halt_pend;   // halt seen while a response is still owed

  logic            halt_eff;
  logic [XLEN-1:0] redirect_target;

  assign halt_eff        = halt | halt_pend;
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // Request valid is decoded from state only, so it never depends on ready.
  assign ifu_req_valid  = (state == REQ);
  assign ifu_req_addr   = pc;
  assign ifu_inst_valid = (state == HOLD) && !redirect_valid && !halt;

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch reads the pre-edge values of pc/state/flush regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      halt_pend <= 1'b0;
      ifu_inst  <= '0;
      ifu_pc    <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (halt_eff) begin
            state <= HALT;
          end else begin
            if (redirect_valid) pc <= redirect_target;
            state <= REQ;
          end
        end

        REQ: begin
          if (halt_eff) begin
            if (ifu_req_ready) begin
              flush     <= 1'b1;
              halt_pend <= 1'b1;
              state     <= WAIT;
            end else begin
              state <= HALT;
            end
          end else if (redirect_valid) begin
            pc <= redirect_target;
            if (ifu_req_ready) begin
              flush <= 1'b1;
              state <= WAIT;
            end
          end else if (ifu_req_ready) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (halt_eff) begin
            halt_pend <= 1'b1;
            if (ifu_rsp_valid) begin
              flush <= 1'b0;
              state <= HALT;
            end else begin
              flush <= 1'b1;
            end
          end else if (redirect_valid) begin
            pc <= redirect_target;
            if (ifu_rsp_valid) begin
              flush <= 1'b0;
              state <= REQ;
            end else begin
              flush <= 1'b1;
            end
          end else if (ifu_rsp_valid) begin
            if (flush) begin
              flush <= 1'b0;
              state <= REQ;
            end else begin
              ifu_inst <= ifu_rsp_data;
              ifu_pc   <= pc;
              state    <= HOLD;
            end
          end
        end

        HOLD: begin
          if (halt_eff) begin
            state <= HALT;
          end else if (redirect_valid) begin
            pc    <= redirect_target;
            state <= REQ;
          end else if (ifu_inst_ready) begin
            pc    <= pc + XLEN'(4);
            state <= REQ;
          end
        end

        HALT: state <= HALT;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: inputs change 1ns after each rising edge and
// outputs are checked just after, well away from the next edge.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_inst_valid;
  logic        ifu_inst_ready;
  logic [31:0] ifu_inst;
  logic [31:0] ifu_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_rsp_valid  (ifu_rsp_valid),
    .ifu_rsp_data   (ifu_rsp_data),
    .ifu_inst_valid (ifu_inst_valid),
    .ifu_inst_ready (ifu_inst_ready),
    .ifu_inst       (ifu_inst),
    .ifu_pc         (ifu_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Full REQ -> WAIT -> HOLD -> handshake with immediate ready/response.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    check("req_valid", 32'(ifu_req_valid), 32'd1);
    check("req_addr", ifu_req_addr, addr);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    check("wait_no_req", 32'(ifu_req_valid), 32'd0);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = data;
    step();
    ifu_rsp_valid = 1'b0;
    ifu_inst_ready = 1'b1;
    settle();
    check("inst_valid", 32'(ifu_inst_valid), 32'd1);
    check("inst", ifu_inst, data);
    check("inst_pc", ifu_pc, addr);
    step();
    ifu_inst_ready = 1'b0;
  endtask

  initial begin
    rst_b          = 1'b0;
    ifu_req_ready  = 1'b0;
    ifu_rsp_valid  = 1'b0;
    ifu_rsp_data   = '0;
    ifu_inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    step();
    step();

    // Reset state
    check("rst_req_valid", 32'(ifu_req_valid), 32'd0);
    check("rst_inst_valid", 32'(ifu_inst_valid), 32'd0);
    check("rst_inst", ifu_inst, 32'h0);
    check("rst_pc", ifu_pc, 32'h8000_0000);
    check("rst_addr", ifu_req_addr, 32'h8000_0000);

    // First edge after release: IDLE -> REQ
    rst_b = 1'b1;
    step();

    // Memory not ready for 4 cycles: request held with stable address
    for (int i = 0; i < 4; i++) begin
      check("stall_req_valid", 32'(ifu_req_valid), 32'd1);
      check("stall_req_addr", ifu_req_addr, 32'h8000_0000);
      step();
    end
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    check("wait_after_accept", 32'(ifu_req_valid), 32'd0);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0010_0093;
    step();
    ifu_rsp_valid = 1'b0;

    // Decode stalls for 5 cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      check("hold_inst_valid", 32'(ifu_inst_valid), 32'd1);
      check("hold_inst", ifu_inst, 32'h0010_0093);
      check("hold_pc", ifu_pc, 32'h8000_0000);
      check("hold_no_req", 32'(ifu_req_valid), 32'd0);
      step();
    end
    ifu_inst_ready = 1'b1;
    step();
    ifu_inst_ready = 1'b0;

    // Back-to-back fetches, 3 cycles each
    fetch_one(32'h8000_0004, 32'h0020_0113);
    fetch_one(32'h8000_0008, 32'h0030_0193);

    // Redirect while waiting for a response; that response is discarded
    check("pre_redir_addr", ifu_req_addr, 32'h8000_000C);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    step();
    redirect_valid = 1'b0;
    check("flush_wait_no_req", 32'(ifu_req_valid), 32'd0);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'hDEAD_BEEF;
    step();
    ifu_rsp_valid = 1'b0;
    check("flush_inst_valid", 32'(ifu_inst_valid), 32'd0);
    check("flush_inst_kept", ifu_inst, 32'h0030_0193);
    check("redir_req_valid", 32'(ifu_req_valid), 32'd1);
    check("redir_req_addr", ifu_req_addr, 32'h8000_0100);

    // Redirect in HOLD with decode ready: instruction dropped
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0040_0213;
    step();
    ifu_rsp_valid  = 1'b0;
    check("hold_pc_0100", ifu_pc, 32'h8000_0100);
    ifu_inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    settle();
    check("redir_hold_masked", 32'(ifu_inst_valid), 32'd0);
    step();
    ifu_inst_ready = 1'b0;
    redirect_valid = 1'b0;
    check("redir_hold_req", 32'(ifu_req_valid), 32'd1);
    check("redir_hold_addr", ifu_req_addr, 32'h8000_0200);

    // Redirect coinciding with request acceptance: response flushed
    ifu_req_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0013;
    step();
    ifu_req_ready  = 1'b0;
    redirect_valid = 1'b0;
    check("acc_redir_wait", 32'(ifu_req_valid), 32'd0);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h1111_1111;
    step();
    ifu_rsp_valid = 1'b0;
    check("acc_redir_inst_valid", 32'(ifu_inst_valid), 32'd0);
    check("acc_redir_addr", ifu_req_addr, 32'h0000_0010);

    // Stray response in REQ is ignored
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h2222_2222;
    step();
    ifu_rsp_valid = 1'b0;
    check("stray_inst_valid", 32'(ifu_inst_valid), 32'd0);
    check("stray_req_valid", 32'(ifu_req_valid), 32'd1);

    // PC wraps to 0 after 0xFFFF_FFFC
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h0050_0293);
    check("wrap_addr", ifu_req_addr, 32'h0000_0000);

    // Halt in WAIT: drain and discard the response, then stay halted
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_drain_no_req", 32'(ifu_req_valid), 32'd0);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h3333_3333;
    step();
    ifu_rsp_valid = 1'b0;
    ifu_inst_ready = 1'b1;
    ifu_req_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("halted_req_valid", 32'(ifu_req_valid), 32'd0);
      check("halted_inst_valid", 32'(ifu_inst_valid), 32'd0);
      step();
    end
    ifu_inst_ready = 1'b0;
    ifu_req_ready  = 1'b0;
    redirect_valid = 1'b0;
    check("halted_inst_kept", ifu_inst, 32'h0050_0293);

    // One-cycle reset resumes fetching from RESET_PC
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    check("rerst_req_valid", 32'(ifu_req_valid), 32'd0);
    check("rerst_inst", ifu_inst, 32'h0);
    check("rerst_pc", ifu_pc, 32'h8000_0000);
    step();
    fetch_one(32'h8000_0000, 32'h0060_0313);
    check("resume_addr", ifu_req_addr, 32'h8000_0004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
